// File: rtl/class_vote_filter.sv
// ---------------------------------------------------------------------------
// class_vote_filter
//
// Smooths a stream of per-frame waveform classifications. It keeps a
// circular history of the last WIN samples and runs a majority vote after
// every sample. A type is reported only once it holds at least MIN_VOTES
// entries in the window.
//
// Ports
//   clk                   clock; all state updates on the rising edge
//   rst_n                 asynchronous active-low reset
//   waveform_type[2:0]    classifier result (0 unknown .. 5 noise)
//   confidence[7:0]       classifier confidence, 0..100
//   classification_valid  single-cycle qualifier for the two inputs above
//   clear                 synchronous flush of history, counters and outputs
//   stable_type[2:0]      voted waveform type
//   stable_confidence[7:0] mean confidence of the winning type over the window
//   stable_valid          one-cycle pulse per completed vote
//   type_changed          one-cycle pulse when a vote changes stable_type
//   fill_count[4:0]       number of valid history entries, 0..WIN
//   stale                 no sample accepted for STALE_CYCLES cycles
//   overrun               one-cycle pulse when an input sample is dropped
// ---------------------------------------------------------------------------
module class_vote_filter #(
    parameter int WIN          = 8,
    parameter int MIN_VOTES    = 5,
    parameter int STALE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] waveform_type,
    input  logic [7:0] confidence,
    input  logic       classification_valid,
    input  logic       clear,
    output logic [2:0] stable_type,
    output logic [7:0] stable_confidence,
    output logic       stable_valid,
    output logic       type_changed,
    output logic [4:0] fill_count,
    output logic       stale,
    output logic       overrun
);
    localparam int IDX_W   = $clog2(WIN);
    localparam int STALE_W = $clog2(STALE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COUNT, DECIDE} state_t;
    state_t state_reg, state_next;

    // History: data fields need no reset; only the valid bits do.
    logic [2:0]       hist_type_reg [WIN];
    logic [6:0]       hist_conf_reg [WIN];
    logic [WIN-1:0]   hist_valid_reg;
    logic [IDX_W-1:0] wr_ptr_reg;
    logic [IDX_W-1:0] rd_idx_reg;

    logic             skid_full_reg;
    logic [2:0]       skid_type_reg;
    logic [6:0]       skid_conf_reg;

    logic [STALE_W-1:0] stale_cnt_reg;

    logic [4:0]  votes [8];
    logic [10:0] sums  [8];

    // Ingest clamping of the live sample
    logic [2:0] live_type;
    logic [6:0] live_conf;
    assign live_type = (waveform_type > 3'd5) ? 3'd0 : waveform_type;
    assign live_conf = (confidence > 8'd100) ? 7'd100 : confidence[6:0];

    // History read port used during COUNT
    logic [2:0] rd_type;
    logic [6:0] rd_conf;
    logic       rd_valid;
    assign rd_type  = hist_type_reg[rd_idx_reg];
    assign rd_conf  = hist_conf_reg[rd_idx_reg];
    assign rd_valid = hist_valid_reg[rd_idx_reg];

    logic       hist_we;
    logic [2:0] wr_type;
    logic [6:0] wr_conf;
    logic       skid_load;
    logic       skid_pop;
    logic       drop;
    logic       accepted;
    logic       stale_hit;

    always_comb begin
        state_next = state_reg;
        hist_we    = 1'b0;
        wr_type    = live_type;
        wr_conf    = live_conf;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        drop       = 1'b0;
        case (state_reg)
            IDLE: begin
                // The parked sample is older, so it goes first; a live
                // sample in the same cycle takes its place in the skid.
                if (skid_full_reg) begin
                    hist_we   = 1'b1;
                    wr_type   = skid_type_reg;
                    wr_conf   = skid_conf_reg;
                    skid_pop  = 1'b1;
                    skid_load = classification_valid;
                end else if (classification_valid) begin
                    hist_we = 1'b1;
                end
                if (hist_we) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (rd_idx_reg == IDX_W'(WIN - 1)) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (state_reg != IDLE && classification_valid) begin
            if (skid_full_reg) begin
                drop = 1'b1;
            end else begin
                skid_load = 1'b1;
            end
        end
        if (clear) begin
            state_next = IDLE;
            hist_we    = 1'b0;
            skid_load  = 1'b0;
            skid_pop   = 1'b0;
            drop       = 1'b0;
        end
    end

    assign accepted  = classification_valid && !clear && !drop;
    assign stale_hit = !accepted && !clear &&
                       (stale_cnt_reg == STALE_W'(STALE_CYCLES - 1));

    // Winner: highest vote count, lowest code on ties, but the current
    // stable_type wins any tie it takes part in.
    logic [2:0]  best_type;
    logic [4:0]  best_votes;
    logic [10:0] best_sum;
    always_comb begin
        best_type  = 3'd0;
        best_votes = votes[0];
        for (int t = 1; t < 6; t++) begin
            if (votes[t] > best_votes) begin
                best_type  = 3'(t);
                best_votes = votes[t];
            end
        end
        if (votes[stable_type] == best_votes) begin
            best_type = stable_type;
        end
        best_sum = sums[best_type];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_type_reg[wr_ptr_reg] <= wr_type;
            hist_conf_reg[wr_ptr_reg] <= wr_conf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_valid_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_idx_reg     <= '0;
        end else if (clear || stale_hit) begin
            hist_valid_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_idx_reg     <= '0;
        end else begin
            if (hist_we) begin
                hist_valid_reg[wr_ptr_reg] <= 1'b1;
                wr_ptr_reg                 <= wr_ptr_reg + 1'b1;
                rd_idx_reg                 <= '0;
            end else if (state_reg == COUNT) begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full_reg <= 1'b0;
            skid_type_reg <= 3'd0;
            skid_conf_reg <= 7'd0;
        end else if (clear || stale_hit) begin
            skid_full_reg <= 1'b0;
        end else if (skid_load) begin
            skid_full_reg <= 1'b1;
            skid_type_reg <= live_type;
            skid_conf_reg <= live_conf;
        end else if (skid_pop) begin
            skid_full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_reg <= '0;
        end else if (clear || accepted) begin
            stale_cnt_reg <= '0;
        end else if (stale_cnt_reg != STALE_W'(STALE_CYCLES)) begin
            stale_cnt_reg <= stale_cnt_reg + 1'b1;
        end
    end

    // Per-type vote and confidence accumulators, restarted with each vote.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_acc
            logic [4:0]  votes_reg;
            logic [10:0] sum_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    votes_reg <= '0;
                    sum_reg   <= '0;
                end else if (clear || hist_we) begin
                    votes_reg <= '0;
                    sum_reg   <= '0;
                end else if (state_reg == COUNT && rd_valid && rd_type == 3'(gi)) begin
                    votes_reg <= votes_reg + 5'd1;
                    sum_reg   <= sum_reg + 11'(rd_conf);
                end
            end
            assign votes[gi] = votes_reg;
            assign sums[gi]  = sum_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_type       <= 3'd0;
            stable_confidence <= 8'd0;
            stable_valid      <= 1'b0;
            type_changed      <= 1'b0;
            fill_count        <= 5'd0;
            stale             <= 1'b0;
            overrun           <= 1'b0;
        end else if (clear) begin
            stable_type       <= 3'd0;
            stable_confidence <= 8'd0;
            stable_valid      <= 1'b0;
            type_changed      <= 1'b0;
            fill_count        <= 5'd0;
            stale             <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            stable_valid <= 1'b0;
            type_changed <= 1'b0;
            overrun      <= drop;
            if (hist_we && fill_count != 5'(WIN)) begin
                fill_count <= fill_count + 5'd1;
            end
            if (state_reg == DECIDE) begin
                stable_valid <= 1'b1;
                if (32'(best_votes) >= MIN_VOTES) begin
                    stable_type       <= best_type;
                    stable_confidence <= 8'(best_sum >> IDX_W);
                    type_changed      <= (best_type != stable_type);
                end
            end
            if (accepted) begin
                stale <= 1'b0;
            end
            // The stale flush overrides anything decided in the same cycle.
            if (stale_hit) begin
                stale             <= 1'b1;
                stable_type       <= 3'd0;
                stable_confidence <= 8'd0;
                fill_count        <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_class_vote_filter.sv
module tb_class_vote_filter;
    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] waveform_type = 3'd0;
    logic [7:0] confidence = 8'd0;
    logic       classification_valid = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] stable_type;
    logic [7:0] stable_confidence;
    logic       stable_valid;
    logic       type_changed;
    logic [4:0] fill_count;
    logic       stale;
    logic       overrun;

    always #5 clk = ~clk;

    class_vote_filter #(
        .WIN(WIN),
        .MIN_VOTES(5),
        .STALE_CYCLES(1000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .waveform_type(waveform_type),
        .confidence(confidence),
        .classification_valid(classification_valid),
        .clear(clear),
        .stable_type(stable_type),
        .stable_confidence(stable_confidence),
        .stable_valid(stable_valid),
        .type_changed(type_changed),
        .fill_count(fill_count),
        .stale(stale),
        .overrun(overrun)
    );

    int total = 0;
    int bad = 0;
    int sv_cnt = 0;
    int tc_cnt = 0;
    int ov_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (stable_valid) sv_cnt <= sv_cnt + 1;
            if (type_changed) tc_cnt <= tc_cnt + 1;
            if (overrun)      ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [7:0] c);
        waveform_type        = t;
        confidence           = c;
        classification_valid = 1'b1;
        tick();
        classification_valid = 1'b0;
    endtask

    // One sample, result checked exactly WIN+2 cycles later; 20 cycles total.
    task automatic vote(input string tag, input logic [2:0] t, input logic [7:0] c,
                        input int et, input int ec, input int etc);
        send(t, c);
        repeat (WIN) tick();
        check({tag, "_early"}, int'(stable_valid), 0);
        tick();
        check({tag, "_valid"}, int'(stable_valid), 1);
        check({tag, "_type"}, int'(stable_type), et);
        check({tag, "_conf"}, int'(stable_confidence), ec);
        check({tag, "_chg"}, int'(type_changed), etc);
        $display("vote %s: in={%0d,%0d} type=%0d conf=%0d changed=%0d fill=%0d",
                 tag, t, c, stable_type, stable_confidence, type_changed, fill_count);
        repeat (20 - WIN - 2) tick();
    endtask

    int exp35_conf [8] = '{0, 0, 0, 0, 60, 72, 84, 96};
    int exp36_type [5] = '{1, 1, 1, 1, 2};
    int exp36_conf [5] = '{84, 72, 60, 60, 56};
    int sv0;
    int ov0;

    initial begin
        // Reset
        repeat (3) tick();
        check("rst_type", int'(stable_type), 0);
        check("rst_conf", int'(stable_confidence), 0);
        check("rst_fill", int'(fill_count), 0);
        check("rst_stale", int'(stale), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_pulses", sv_cnt + tc_cnt + ov_cnt, 0);
        check("idle_fill", int'(fill_count), 0);
        check("idle_stale", int'(stale), 0);

        // Eight {1,96} samples
        for (int i = 0; i < 8; i++) begin
            vote($sformatf("s1_%0d", i + 1), 3'd1, 8'd96, (i >= 4) ? 1 : 0,
                 exp35_conf[i], (i == 4) ? 1 : 0);
        end
        check("s1_fill", int'(fill_count), 8);
        check("s1_tc_total", tc_cnt, 1);

        // Five {2,90}: 4:4 tie keeps type 1, fifth switches to type 2
        for (int i = 0; i < 5; i++) begin
            vote($sformatf("s2_%0d", i + 1), 3'd2, 8'd90, exp36_type[i],
                 exp36_conf[i], (i == 4) ? 1 : 0);
        end

        // clear together with a valid sample: sample discarded, no overrun
        sv0 = sv_cnt;
        ov0 = ov_cnt;
        waveform_type = 3'd3;
        confidence = 8'd50;
        classification_valid = 1'b1;
        clear = 1'b1;
        tick();
        classification_valid = 1'b0;
        clear = 1'b0;
        check("clr_type", int'(stable_type), 0);
        check("clr_conf", int'(stable_confidence), 0);
        check("clr_fill", int'(fill_count), 0);
        repeat (15) tick();
        check("clr_no_vote", sv_cnt - sv0, 0);
        check("clr_no_ovr", ov_cnt - ov0, 0);
        check("clr_fill2", int'(fill_count), 0);

        // Three back-to-back samples: live, skid, dropped
        sv0 = sv_cnt;
        ov0 = ov_cnt;
        waveform_type = 3'd3;
        confidence = 8'd50;
        classification_valid = 1'b1;
        repeat (3) tick();
        classification_valid = 1'b0;
        repeat (30) tick();
        check("burst_votes", sv_cnt - sv0, 2);
        check("burst_ovr", ov_cnt - ov0, 1);
        check("burst_fill", int'(fill_count), 2);
        check("burst_type", int'(stable_type), 0);
        $display("burst: votes=%0d overruns=%0d fill=%0d", sv_cnt - sv0, ov_cnt - ov0, fill_count);

        // Establish type 1, then go idle into stale
        for (int i = 0; i < 5; i++) begin
            vote($sformatf("s3_%0d", i + 1), 3'd1, 8'd96, (i == 4) ? 1 : 0,
                 (i == 4) ? 60 : 0, (i == 4) ? 1 : 0);
        end
        repeat (980) tick();
        check("stale_before", int'(stale), 0);
        check("stale_before_type", int'(stable_type), 1);
        tick();
        check("stale_set", int'(stale), 1);
        check("stale_type", int'(stable_type), 0);
        check("stale_conf", int'(stable_confidence), 0);
        check("stale_fill", int'(fill_count), 0);
        $display("stale: stale=%0d type=%0d conf=%0d fill=%0d", stale, stable_type,
                 stable_confidence, fill_count);

        // Out-of-range input {7,150} is stored as {0,100}
        for (int i = 0; i < 5; i++) begin
            vote($sformatf("s4_%0d", i + 1), 3'd7, 8'd150, 0, (i == 4) ? 62 : 0, 0);
            if (i == 0) begin
                check("stale_clr", int'(stale), 0);
                check("stale_fill1", int'(fill_count), 1);
            end
        end

        // clear during the third COUNT cycle aborts the vote
        sv0 = sv_cnt;
        send(3'd5, 8'd40);
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_type", int'(stable_type), 0);
        check("abort_conf", int'(stable_confidence), 0);
        check("abort_fill", int'(fill_count), 0);
        check("abort_valid", int'(stable_valid), 0);
        repeat (15) tick();
        check("abort_no_vote", sv_cnt - sv0, 0);
        vote("after_abort", 3'd4, 8'd20, 0, 0, 0);
        check("after_abort_fill", int'(fill_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
